noc_synth_client: RTL and testbench

- Parametrised synthetic-traffic endpoint for the BFT NoC; one instance per leaf port of a t_switch tree.
- Generalises the current single-mode client:
  - NUM_VC credit-tracked injection channels
  - four destination patterns
  - per-VC receive buffering with rate-limited drain and credit return
  - packet counters and a completion flag
- The tx side connects to a switch's l/r_rx; the rx side connects to its l/r_tx.

---
 rtl/noc_client_pkg.sv | 42 ++++
 rtl/noc_synth_client_fifo.sv | 54 +++++
 rtl/noc_synth_client.sv | 246 ++++++++++++++++++++++++
 tb/tb_noc_synth_client.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_client_pkg.sv
// rtl/noc_client_pkg.sv - shared types, LFSR polynomial and packet field helpers for noc_synth_client
package noc_client_pkg;

  typedef enum logic [1:0] {
    MODE_RANDOM    = 2'd0,
    MODE_BITCOMP   = 2'd1,
    MODE_NEIGHBOUR = 2'd2,
    MODE_HOTSPOT   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } client_state_e;

  // Right-shifting Galois toggle mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  function automatic logic [63:0] field_mask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Packet layout is {dest[a_w], src[a_w], seq[d_w-a_w]}
  function automatic logic [31:0] pkt_dest(input logic [63:0] pkt, input int a_w, input int d_w);
    return 32'((pkt >> d_w) & field_mask(a_w));
  endfunction

  function automatic logic [31:0] pkt_src(input logic [63:0] pkt, input int a_w, input int d_w);
    return 32'((pkt >> (d_w - a_w)) & field_mask(a_w));
  endfunction

  function automatic logic [31:0] pkt_seq(input logic [63:0] pkt, input int a_w, input int d_w);
    return 32'(pkt & field_mask(d_w - a_w));
  endfunction

endpackage

// File: rtl/noc_synth_client_fifo.sv
// rtl/noc_synth_client_fifo.sv - noc_vc_fifo: small synchronous show-ahead FIFO for one receive VC
module noc_vc_fifo #(
  parameter int DEPTH = 3,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_rd, do_wr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_rd     = rd_en_i && !empty_o;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands
  assign do_wr     = wr_en_i && (!full_o || do_rd);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_wr && !do_rd)      count_q <= count_q + CW'(1);
      else if (!do_wr && do_rd) count_q <= count_q - CW'(1);
    end
  end

  // Storage array, no reset needed since occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/noc_synth_client.sv
// rtl/noc_synth_client.sv - synthetic traffic NoC endpoint; optional checker under NOC_CLIENT_CHECK_EN
module noc_synth_client
  import noc_client_pkg::*;
#(
  parameter int N             = 4,
  parameter int A_W           = 3,
  parameter int D_W           = 32,
  parameter int VC_W          = 4,
  parameter int VC_FIFO_DEPTH = 4,
  parameter int POSX          = 0,
  parameter int HOTSPOT       = 0,
  parameter int LIMIT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [6:0]         rate,
  input  logic [6:0]         bp_rate,
  input  logic [LIMIT_W-1:0] synthetic_limit,
  output logic [VC_W-1:0]    tx_vc_target,
  output logic [A_W+D_W-1:0] tx_packet,
  input  logic [VC_W-1:0]    tx_credit_gnt,
  input  logic [VC_W-1:0]    rx_vc_target,
  input  logic [A_W+D_W-1:0] rx_packet,
  output logic [VC_W-1:0]    rx_credit_gnt,
  output logic [LIMIT_W-1:0] sent_count,
  output logic [LIMIT_W-1:0] recv_count,
  output logic               done,
  output logic               err
);

  localparam int P_W    = A_W + D_W;
  localparam int SEQ_W  = D_W - A_W;
  localparam int CRED_W = $clog2(VC_FIFO_DEPTH);
  localparam int VCI_W  = (VC_W > 1) ? $clog2(VC_W) : 1;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(VC_FIFO_DEPTH - 1);
  localparam logic [31:0] INJ_SEED = (32'hACE1_3579 ^ (32'(POSX) * 32'h9E37_79B9)) | 32'h1;
  localparam logic [31:0] BP_SEED  = (32'h5EED_B00F ^ (32'(POSX) * 32'h85EB_CA6B)) | 32'h1;
  localparam logic [A_W-1:0] SELF    = A_W'(POSX);
  localparam logic [A_W-1:0] NEIGH   = A_W'((POSX + 1) % N);
  localparam logic [A_W-1:0] BITCOMP = A_W'(~POSX & (N - 1));
  localparam logic [A_W-1:0] HOT     = A_W'(HOTSPOT);

  client_state_e state_q, state_d;
  logic [31:0]              lfsr_q, bp_lfsr_q;
  logic [CRED_W-1:0]        cred_q [VC_W];
  logic [VCI_W-1:0]         last_tx_q, last_rx_q;
  logic [VC_W-1:0]          tx_vc_q, gnt_q;
  logic [P_W-1:0]           tx_pkt_q;
  logic [LIMIT_W-1:0]       sent_q, recv_q;
  logic                     done_q;

  logic [VC_W-1:0]          has_cred, cred_full, fifo_full, fifo_empty, inj, pop, wr_en;
  logic [VC_W-1:0][P_W-1:0] rd_data;
  logic [VCI_W-1:0]         tx_sel, rx_sel;
  logic                     tx_found, rx_found, rate_hit, stall, fire, pop_any, quiet;
  logic [A_W-1:0]           rnd, dest_raw, dest;

  // Per-VC credit and FIFO status vectors
  always_comb begin
    has_cred  = '0;
    cred_full = '0;
    for (int v = 0; v < VC_W; v++) begin
      has_cred[v]  = (cred_q[v] != '0);
      cred_full[v] = (cred_q[v] == CRED_MAX);
    end
  end

  // Round-robin VC choice for injection, starting after the last used VC
  always_comb begin
    tx_found = 1'b0;
    tx_sel   = '0;
    for (int k = 1; k <= VC_W; k++) begin
      if (!tx_found && has_cred[(int'(last_tx_q) + k) % VC_W]) begin
        tx_found = 1'b1;
        tx_sel   = VCI_W'((int'(last_tx_q) + k) % VC_W);
      end
    end
  end

  // Round-robin choice of the non-empty receive FIFO to drain
  always_comb begin
    rx_found = 1'b0;
    rx_sel   = '0;
    for (int k = 1; k <= VC_W; k++) begin
      if (!rx_found && !fifo_empty[(int'(last_rx_q) + k) % VC_W]) begin
        rx_found = 1'b1;
        rx_sel   = VCI_W'((int'(last_rx_q) + k) % VC_W);
      end
    end
  end

  // A rate of 100 or more means every cycle, which mod-128 sampling alone cannot reach
  assign rate_hit = (rate >= 7'd100) || (lfsr_q[6:0] < rate);
  assign stall    = (bp_rate >= 7'd100) || (bp_lfsr_q[6:0] < bp_rate);
  assign fire     = (state_q == RUN) && rate_hit && tx_found && (sent_q != synthetic_limit);
  assign inj      = fire ? (VC_W'(1) << tx_sel) : '0;
  assign pop_any  = rx_found && !stall;
  assign pop      = pop_any ? (VC_W'(1) << rx_sel) : '0;
  assign wr_en    = rx_vc_target & (~fifo_full | pop);
  assign quiet    = (&cred_full) && (&fifo_empty);

  // Destination selection; the MSB is the switch-level bit and stays 0 for leaves
  always_comb begin
    rnd            = '0;
    rnd[A_W-2:0]   = lfsr_q[A_W-2:0];
    dest_raw       = HOT;
    case (mode)
      MODE_RANDOM:    dest_raw = (rnd == SELF) ? NEIGH : rnd;
      MODE_BITCOMP:   dest_raw = BITCOMP;
      MODE_NEIGHBOUR: dest_raw = NEIGH;
      default:        dest_raw = HOT;
    endcase
    dest = {1'b0, dest_raw[A_W-2:0]};
  end

  // Injection FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (synthetic_limit == '0) ? DRAIN : RUN;
      RUN:     if (sent_q == synthetic_limit) state_d = DRAIN;
      DRAIN:   if (quiet) state_d = DONE;
      default: state_d = DONE;
    endcase
  end

  // Credit counters: inject takes one, gnt returns one, a gnt at full saturates
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_W; v++) begin
      if (!rst)                                     cred_q[v] <= CRED_MAX;
      else if (inj[v] && !tx_credit_gnt[v])         cred_q[v] <= cred_q[v] - CRED_W'(1);
      else if (!inj[v] && tx_credit_gnt[v] && !cred_full[v])
                                                    cred_q[v] <= cred_q[v] + CRED_W'(1);
    end
  end

  // FSM, LFSRs, registered tx/credit outputs and packet counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      lfsr_q    <= INJ_SEED;
      bp_lfsr_q <= BP_SEED;
      last_tx_q <= VCI_W'(VC_W - 1);
      last_rx_q <= VCI_W'(VC_W - 1);
      tx_vc_q   <= '0;
      tx_pkt_q  <= '0;
      gnt_q     <= '0;
      sent_q    <= '0;
      recv_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_next(lfsr_q);
      bp_lfsr_q <= lfsr_next(bp_lfsr_q);
      tx_vc_q   <= inj;
      tx_pkt_q  <= fire ? {dest, SELF, SEQ_W'(sent_q)} : '0;
      gnt_q     <= pop;
      done_q    <= (state_d == DONE);
      if (fire) begin
        sent_q    <= sent_q + LIMIT_W'(1);
        last_tx_q <= tx_sel;
      end
      if (pop_any) begin
        recv_q    <= recv_q + LIMIT_W'(1);
        last_rx_q <= rx_sel;
      end
    end
  end

  for (genvar v = 0; v < VC_W; v++) begin : g_fifo
    noc_vc_fifo #(
      .DEPTH(VC_FIFO_DEPTH - 1),
      .W    (P_W)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (wr_en[v]),
      .wr_data_i(rx_packet),
      .rd_en_i  (pop[v]),
      .rd_data_o(rd_data[v]),
      .full_o   (fifo_full[v]),
      .empty_o  (fifo_empty[v])
    );
  end

`ifdef NOC_CLIENT_CHECK_EN
  localparam int SRC_IW = $clog2(N);

  logic [SEQ_W-1:0]  last_seq_q [N][VC_W];
  logic [VC_W-1:0]   seq_vld_q [N];
  logic              err_q;
  logic [P_W-1:0]    chk_pkt;
  logic [A_W-1:0]    chk_dst, chk_src;
  logic [SEQ_W-1:0]  chk_seq, chk_diff;
  logic [SRC_IW-1:0] chk_si;
  logic              src_ok, hdr_bad, seq_bad, cred_ovf, rx_ovf;

  // Decode the flit being drained and flag header, ordering and overflow faults
  always_comb begin
    chk_pkt  = rd_data[rx_sel];
    chk_dst  = A_W'(pkt_dest(64'(chk_pkt), A_W, D_W));
    chk_src  = A_W'(pkt_src(64'(chk_pkt), A_W, D_W));
    chk_seq  = SEQ_W'(pkt_seq(64'(chk_pkt), A_W, D_W));
    chk_si   = chk_src[SRC_IW-1:0];
    src_ok   = (chk_src < A_W'(N)) && (chk_src != SELF);
    chk_diff = chk_seq - last_seq_q[chk_si][rx_sel];
    hdr_bad  = pop_any && ((chk_dst != SELF) || !src_ok);
    // Seq must advance by less than half the seq space to count as newer
    seq_bad  = pop_any && src_ok && seq_vld_q[chk_si][rx_sel] &&
               ((chk_diff == '0) || chk_diff[SEQ_W-1]);
    cred_ovf = |(tx_credit_gnt & ~inj & cred_full);
    rx_ovf   = |(rx_vc_target & fifo_full & ~pop);
  end

  // Sticky error flag and per-(src,VC) seq-seen flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
      for (int s = 0; s < N; s++) seq_vld_q[s] <= '0;
    end else begin
      err_q <= err_q | hdr_bad | seq_bad | cred_ovf | rx_ovf;
      if (pop_any && src_ok) seq_vld_q[chk_si][rx_sel] <= 1'b1;
    end
  end

  // Last accepted seq per (src,VC); only meaningful once its valid flag is set
  always_ff @(posedge clk) begin
    if (pop_any && src_ok) last_seq_q[chk_si][rx_sel] <= chk_seq;
  end

  assign err = err_q;
`else
  logic rx_data_unused;
  assign rx_data_unused = ^rd_data;
  assign err = 1'b0;
`endif

  assign tx_vc_target  = tx_vc_q;
  assign tx_packet     = tx_pkt_q;
  assign rx_credit_gnt = gnt_q;
  assign sent_count    = sent_q;
  assign recv_count    = recv_q;
  assign done          = done_q;

endmodule

// File: tb/tb_noc_synth_client.sv
// tb/tb_noc_synth_client.sv - directed self-checking bench for noc_synth_client (POSX=1, HOTSPOT=3)
module tb_noc_synth_client;

`ifdef NOC_CLIENT_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic [6:0]  rate, bp_rate;
  logic [15:0] limit;
  logic [3:0]  tx_vc_target, tx_credit_gnt, rx_vc_target, rx_credit_gnt;
  logic [34:0] tx_packet, rx_packet;
  logic [15:0] sent_count, recv_count;
  logic        done, err;

  logic        loop_en;
  logic [1:0]  gsel;
  logic [3:0]  gnt_drv, rx_vc_drv;
  logic [34:0] rx_pkt_drv;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt, bad, waitc;
  int hist [4];
  logic [3:0] last_vc;

  // Loopback swaps dest/src so the returning flit is addressed to this client
  assign rx_vc_target  = loop_en ? tx_vc_target : rx_vc_drv;
  assign rx_packet     = loop_en ? {tx_packet[31:29], tx_packet[34:32], tx_packet[28:0]} : rx_pkt_drv;
  assign tx_credit_gnt = (gsel == 2'd1) ? rx_credit_gnt :
                         (gsel == 2'd2) ? tx_vc_target  : gnt_drv;

  noc_synth_client #(
    .N(4), .A_W(3), .D_W(32), .VC_W(4), .VC_FIFO_DEPTH(4),
    .POSX(1), .HOTSPOT(3), .LIMIT_W(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mode           (mode),
    .rate           (rate),
    .bp_rate        (bp_rate),
    .synthetic_limit(limit),
    .tx_vc_target   (tx_vc_target),
    .tx_packet      (tx_packet),
    .tx_credit_gnt  (tx_credit_gnt),
    .rx_vc_target   (rx_vc_target),
    .rx_packet      (rx_packet),
    .rx_credit_gnt  (rx_credit_gnt),
    .sent_count     (sent_count),
    .recv_count     (recv_count),
    .done           (done),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_tx_vc"}, tx_vc_target, 0);
    chk({tag, "_tx_pkt"}, tx_packet, 0);
    chk({tag, "_rx_gnt"}, rx_credit_gnt, 0);
    chk({tag, "_sent"}, sent_count, 0);
    chk({tag, "_recv"}, recv_count, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic hold_reset();
    rst = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    rst = 1'b0; mode = 2'd2; rate = 7'd0; bp_rate = 7'd0; limit = 16'd0;
    loop_en = 1'b0; gsel = 2'd0; gnt_drv = '0; rx_vc_drv = '0; rx_pkt_drv = '0;
    repeat (3) cyc();
    chk_zero_outputs("reset");

    // Loopback, neighbour mode: dest = 2, VCs rotate 1,2,4,8, seq counts up
    mode = 2'd2; rate = 7'd100; bp_rate = 7'd0; limit = 16'd20; loop_en = 1'b1; gsel = 2'd1;
    rst = 1'b1;
    cyc();
    chk("lb_first_cycle_idle", tx_vc_target, 0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk($sformatf("lb_vc_%0d", i), tx_vc_target, 64'(1 << (i % 4)));
      chk($sformatf("lb_dest_%0d", i), tx_packet[34:32], 2);
      chk($sformatf("lb_src_%0d", i), tx_packet[31:29], 1);
      chk($sformatf("lb_seq_%0d", i), tx_packet[28:0], 64'(i));
    end
    cyc();
    chk("lb_idle_after_limit", tx_vc_target, 0);
    chk("lb_sent", sent_count, 20);
    waitc = 0;
    while (!done && waitc < 100) begin cyc(); waitc++; end
    chk("lb_done", done, 1);
    chk("lb_recv", recv_count, 20);
    chk("lb_err", err, 0);

    // No credit return, bit-complement: exactly 12 flits, all to dest 2
    hold_reset();
    loop_en = 1'b0; gsel = 2'd0; mode = 2'd1; limit = 16'd50; rate = 7'd100;
    rst = 1'b1;
    cnt = 0; bad = 0;
    repeat (30) begin
      cyc();
      if (tx_vc_target != 0) begin
        cnt++;
        if (tx_packet[34:32] != 3'd2) bad++;
      end
    end
    chk("nc_flits", cnt, 12);
    chk("nc_sent", sent_count, 12);
    chk("bc_dest_errors", bad, 0);
    gnt_drv = 4'b0100;
    cyc();
    gnt_drv = 4'b0000;
    cnt = 0; last_vc = '0;
    repeat (10) begin
      cyc();
      if (tx_vc_target != 0) begin cnt++; last_vc = tx_vc_target; end
    end
    chk("nc_one_more_flit", cnt, 1);
    chk("nc_one_more_vc", last_vc, 4'b0100);
    chk("nc_sent_after_gnt", sent_count, 13);
    chk("nc_err", err, 0);

    // Hotspot: 8 flits all to 3; credits never come back so done stays low
    hold_reset();
    mode = 2'd3; limit = 16'd8; rate = 7'd100;
    rst = 1'b1;
    cnt = 0; bad = 0;
    repeat (20) begin
      cyc();
      if (tx_vc_target != 0) begin
        cnt++;
        if (tx_packet[34:32] != 3'd3 || tx_packet[31:29] != 3'd1) bad++;
      end
    end
    chk("hs_flits", cnt, 8);
    chk("hs_dest_errors", bad, 0);
    chk("hs_not_done", done, 0);

    // Random mode over 1000 flits in loopback: never self, others well represented
    hold_reset();
    mode = 2'd0; limit = 16'd1000; rate = 7'd100; loop_en = 1'b1; gsel = 2'd1;
    for (int d = 0; d < 4; d++) hist[d] = 0;
    rst = 1'b1;
    cnt = 0; waitc = 0;
    while (cnt < 1000 && waitc < 3000) begin
      cyc(); waitc++;
      if (tx_vc_target != 0) begin
        cnt++;
        hist[tx_packet[33:32]]++;
        if (tx_packet[34]) hist[1]++;
      end
    end
    chk("rnd_flits", cnt, 1000);
    chk("rnd_never_self", hist[1], 0);
    chk("rnd_dest0_min", hist[0] >= 200, 1);
    chk("rnd_dest2_min", hist[2] >= 200, 1);
    chk("rnd_dest3_min", hist[3] >= 200, 1);
    waitc = 0;
    while (!done && waitc < 200) begin cyc(); waitc++; end
    chk("rnd_done", done, 1);
    chk("rnd_recv", recv_count, 1000);
    chk("rnd_err", err, 0);

    // Receive side: three flits held by full backpressure, fourth overflows
    hold_reset();
    loop_en = 1'b0; gsel = 2'd0; rate = 7'd0; limit = 16'd0; bp_rate = 7'd100;
    rst = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      rx_vc_drv = 4'b0001;
      rx_pkt_drv = {3'd1, 3'd0, 29'(k)};
      cyc();
    end
    rx_vc_drv = '0;
    bad = 0;
    repeat (3) begin
      cyc();
      if (rx_credit_gnt != 0) bad++;
    end
    chk("rx_no_gnt_when_stalled", bad, 0);
    chk("rx_recv_stalled", recv_count, 0);
    rx_vc_drv = 4'b0001;
    rx_pkt_drv = {3'd1, 3'd0, 29'd3};
    cyc();
    rx_vc_drv = '0;
    cyc();
    chk("rx_overflow_err", err, 64'(CHK));
    bp_rate = 7'd0;
    cyc();
    chk("rx_gnt_0", rx_credit_gnt, 4'b0001);
    cyc();
    chk("rx_gnt_1", rx_credit_gnt, 4'b0001);
    cyc();
    chk("rx_gnt_2", rx_credit_gnt, 4'b0001);
    cyc();
    chk("rx_gnt_3_idle", rx_credit_gnt, 4'b0000);
    chk("rx_recv", recv_count, 3);

    // Credit returned in the same cycle as each inject: no stall for 100 cycles
    hold_reset();
    mode = 2'd2; limit = 16'd1000; rate = 7'd100; bp_rate = 7'd0; gsel = 2'd2;
    rst = 1'b1;
    cyc();
    cnt = 0;
    repeat (100) begin
      cyc();
      if (tx_vc_target != 0) cnt++;
    end
    chk("sim_gnt_flits", cnt, 100);
    chk("sim_gnt_sent", sent_count, 100);
    chk("sim_gnt_err", err, 0);
    rst = 1'b0;
    cyc();
    chk_zero_outputs("midreset");
    gsel = 2'd0;
    cyc();
    rst = 1'b1;
    cnt = 0;
    repeat (30) begin
      cyc();
      if (tx_vc_target != 0) cnt++;
    end
    chk("midreset_credits_restored", cnt, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
